pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of the datapath payload (PC, operands, immediates).
REQ-002 SHALL have parameter CTRL_W, default 8: width of the control bundle (Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite).
REQ-003 SHALL have parameter BUBBLE_CTRL, default 0: the control value presented whenever the stage holds no valid entry.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream stage offers an entry.
REQ-007 SHALL have port in_ready, output, 1 bit: the stage accepts an entry this cycle.
REQ-008 SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-009 SHALL have port in_ctrl, input, CTRL_W bits: upstream control bundle.
REQ-010 SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the head entry.
REQ-012 SHALL have port out_data, output, DATA_W bits: head payload.
REQ-013 SHALL have port out_ctrl, output, CTRL_W bits: head control bundle.
REQ-014 SHALL have port stall, input, 1 bit: hazard hold; the head entry is not released.
REQ-015 SHALL have port flush, input, 1 bit: branch-taken kill; discards all held entries.
REQ-016 SHALL have port occupancy, output, 2 bits: number of held entries (0 to 2).
REQ-017 SHALL have port stall_cnt, output, 32 bits: performance counter (see Configuration).
REQ-018 SHALL have port flush_cnt, output, 32 bits: performance counter (see Configuration).

Function
REQ-019 SHALL hold two entries, main (the head) and skid, and SHALL preserve FIFO order.
REQ-020 An accept SHALL occur when in_valid=1 and in_ready=1; a release SHALL occur when out_valid=1, out_ready=1 and stall=0.
REQ-021 in_ready SHALL be registered and SHALL equal NOT(skid valid); it SHALL have no combinational path from out_ready or stall.
REQ-022 Latency SHALL be 1 cycle: an entry accepted while the stage is empty SHALL appear at out_* on the next cycle.
REQ-023 With occupancy 1, a simultaneous accept and release SHALL replace main with the new entry, leaving occupancy at 1.
REQ-024 With occupancy 1, an accept without a release SHALL place the new entry in skid, and the next cycle SHALL show in_ready=0.
REQ-025 With occupancy 2, a release SHALL move skid into main, occupancy SHALL become 1, and in_ready SHALL become 1 on the next cycle.
REQ-026 When out_valid=0, out_ctrl SHALL equal BUBBLE_CTRL and out_data SHALL keep its last value.
REQ-027 flush=1 SHALL invalidate both entries at the clock edge, and any entry accepted in the same cycle SHALL be dropped; flush overrides stall and release.
REQ-028 stall=1 SHALL freeze main; accepts into free slots SHALL continue.

Reset
REQ-029 While reset=0: main and skid invalid, out_valid=0, out_data=0, out_ctrl=BUBBLE_CTRL, occupancy=0, in_ready=1, both counters 0.
REQ-030 Assertion of reset mid-operation SHALL discard held entries immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro PIPE_STAGE_REG_PERF_EN defined: stall_cnt SHALL increment on every cycle with stall=1 and out_valid=1, and flush_cnt SHALL increment on every flush=1 cycle; both SHALL saturate at 32'hFFFF_FFFF.
REQ-032 Macro PIPE_STAGE_REG_PERF_EN undefined: no counter logic SHALL be present, and stall_cnt and flush_cnt SHALL be tied to 0.

Verification
REQ-033 Sequence: reset low, then released; in_valid=1, in_data=64'h1000, in_ctrl=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=64'h1000, out_ctrl=8'hA5, occupancy=1.
REQ-034 Sequence: out_ready=0, then present entries 0x1, 0x2, 0x3 -> 0x1 and 0x2 held, occupancy=2, in_ready=0, 0x3 not accepted; then out_ready=1 -> release order 0x1, 0x2, then 0x3.
REQ-035 Sequence: continuous in_valid with out_ready=1 and values 0..9 -> one entry per cycle, in order, in_ready constantly 1.
REQ-036 Sequence: occupancy=2, then flush=1 with in_valid=1 in the same cycle -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, occupancy=0, flushed input never released.
REQ-037 Sequence: stall=1 for 3 cycles with a valid head -> out_* unchanged; with PIPE_STAGE_REG_PERF_EN defined, stall_cnt=3; without it, stall_cnt=0.
REQ-038 Sequence: reset asserted while occupancy=2 between clock edges -> out_valid=0 and in_ready=1 immediately.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with valid/ready handshake,
// hazard stall and branch flush. FIFO order is preserved; in_ready comes
// straight from a flop, so there is no combinational path from out_ready or stall.
// Optional performance counters are enabled by defining PIPE_STAGE_REG_PERF_EN;
// without it stall_cnt and flush_cnt are tied to zero.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W      = 64,
  parameter int unsigned       CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  logic              main_valid_q, skid_valid_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic              accept, release_head;

  // Handshake qualifiers; the skid slot is the only thing that can refuse input.
  always_comb begin
    accept       = in_valid & ~skid_valid_q;
    release_head = main_valid_q & out_ready & ~stall;
  end

  // Entry storage: main is the head, skid catches the entry that arrives while main is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      main_ctrl_q  <= BUBBLE_CTRL;
      skid_ctrl_q  <= BUBBLE_CTRL;
    end else if (flush) begin
      // Kill everything, including an entry offered this cycle.
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!main_valid_q || release_head) begin
      // Head slot is free after this edge: refill from skid first, then from input.
      if (skid_valid_q) begin
        main_valid_q <= 1'b1;
        main_data_q  <= skid_data_q;
        main_ctrl_q  <= skid_ctrl_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        main_valid_q <= 1'b1;
        main_data_q  <= in_data;
        main_ctrl_q  <= in_ctrl;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data;
      skid_ctrl_q  <= in_ctrl;
    end
  end

  // Output view of the head; payload is left untouched when the stage is empty.
  always_comb begin
    in_ready  = ~skid_valid_q;
    out_valid = main_valid_q;
    out_data  = main_data_q;
    out_ctrl  = main_valid_q ? main_ctrl_q : BUBBLE_CTRL;
    occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  end

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters: stalls that actually hold a valid head, and flush cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && main_valid_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed sequences with literal
// expectations plus randomized traffic compared every cycle against a queue model.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] BUB = 8'h00;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    occupancy;
  logic [31:0]   stall_cnt, flush_cnt;

  pipe_stage_reg #(
    .DATA_W      (DW),
    .CTRL_W      (CW),
    .BUBBLE_CTRL (BUB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall     (stall),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a FIFO of up to two entries plus event tallies.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] m_last_data = '0;
  longint        m_stall = 0;
  longint        m_flush = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_last_data = '0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      bit acc, rel;
      acc = in_valid && (q.size() < 2);
      rel = (q.size() > 0) && out_ready && !stall;
      if (stall && q.size() > 0) m_stall++;
      if (flush) begin
        m_flush++;
        q.delete();
      end else begin
        if (rel) void'(q.pop_front());
        if (acc) q.push_back('{d: in_data, c: in_ctrl});
      end
      if (q.size() > 0) m_last_data = q[0].d;
    end
  end

  function automatic logic [31:0] exp_cnt(input longint n);
`ifdef PIPE_STAGE_REG_PERF_EN
    return (n > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : n[31:0];
`else
    return (n < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("m_out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      check("m_in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
      check("m_occupancy", {62'd0, occupancy}, 64'(q.size()));
      check("m_out_data", out_data, m_last_data);
      check("m_out_ctrl", {56'd0, out_ctrl}, {56'd0, (q.size() > 0) ? q[0].c : BUB});
      check("m_stall_cnt", {32'd0, stall_cnt}, {32'd0, exp_cnt(m_stall)});
      check("m_flush_cnt", {32'd0, flush_cnt}, {32'd0, exp_cnt(m_flush)});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit ordy, input bit st, input bit fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  logic [31:0] base_stall;

  initial begin
    #12;
    check_en = 1'b1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_ctrl", {56'd0, out_ctrl}, {56'd0, BUB});
    check("rst_occupancy", {62'd0, occupancy}, 64'd0);
    check("rst_cnt", {stall_cnt, flush_cnt}, 64'd0);
    step();
    reset = 1'b1;
    step();

    // Single entry, one-cycle latency, then bubble with held payload.
    drive(1, 64'h1000, 8'hA5, 1, 0, 0);
    step();
    check("lat_valid", {63'd0, out_valid}, 64'd1);
    check("lat_data", out_data, 64'h1000);
    check("lat_ctrl", {56'd0, out_ctrl}, 64'hA5);
    check("lat_occ", {62'd0, occupancy}, 64'd1);
    drive(0, 64'h0, 8'h00, 1, 0, 0);
    step();
    check("bub_valid", {63'd0, out_valid}, 64'd0);
    check("bub_ctrl", {56'd0, out_ctrl}, {56'd0, BUB});
    check("bub_data", out_data, 64'h1000);

    // Back-pressure fills main and skid; third entry refused.
    drive(1, 64'h1, 8'h01, 0, 0, 0);
    step();
    drive(1, 64'h2, 8'h02, 0, 0, 0);
    step();
    drive(1, 64'h3, 8'h03, 0, 0, 0);
    step();
    check("bp_occ", {62'd0, occupancy}, 64'd2);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_head", out_data, 64'h1);
    drive(1, 64'h3, 8'h03, 1, 0, 0);
    step();
    check("bp_rel1", out_data, 64'h2);
    check("bp_rel1_occ", {62'd0, occupancy}, 64'd1);
    check("bp_rel1_rdy", {63'd0, in_ready}, 64'd1);
    step();
    check("bp_rel2", out_data, 64'h3);
    check("bp_rel2_occ", {62'd0, occupancy}, 64'd1);
    drive(0, 64'h0, 8'h00, 1, 0, 0);
    step();
    check("bp_drain", {62'd0, occupancy}, 64'd0);

    // Streaming at full rate.
    for (int i = 0; i < 10; i++) begin
      drive(1, 64'(i), 8'(i + 16), 1, 0, 0);
      step();
      check("str_data", out_data, 64'(i));
      check("str_rdy", {63'd0, in_ready}, 64'd1);
    end
    drive(0, 64'h0, 8'h00, 1, 0, 0);
    step();

    // Flush with full stage and an input offered in the same cycle.
    drive(1, 64'h11, 8'h11, 0, 0, 0);
    step();
    drive(1, 64'h22, 8'h22, 0, 0, 0);
    step();
    check("fl_pre_occ", {62'd0, occupancy}, 64'd2);
    drive(1, 64'h33, 8'h33, 1, 1, 1);
    step();
    check("fl_valid", {63'd0, out_valid}, 64'd0);
    check("fl_ctrl", {56'd0, out_ctrl}, {56'd0, BUB});
    check("fl_occ", {62'd0, occupancy}, 64'd0);
    drive(0, 64'h0, 8'h00, 1, 0, 0);
    step();
    step();
    check("fl_never_rel", {63'd0, out_valid}, 64'd0);

    // Stall holds the head for three cycles.
    drive(1, 64'h44, 8'h44, 1, 0, 0);
    step();
    base_stall = stall_cnt;
    drive(0, 64'h0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_data", out_data, 64'h44);
      check("st_valid", {63'd0, out_valid}, 64'd1);
      check("st_ctrl", {56'd0, out_ctrl}, 64'h44);
    end
`ifdef PIPE_STAGE_REG_PERF_EN
    check("st_cnt", {32'd0, stall_cnt - base_stall}, 64'd3);
`else
    check("st_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
    drive(0, 64'h0, 8'h00, 1, 0, 0);
    step();
    check("st_rel", {63'd0, out_valid}, 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), {$urandom, $urandom}, 8'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0));
      step();
    end

    // Asynchronous reset with a full stage.
    drive(1, 64'h55, 8'h55, 0, 0, 0);
    step();
    drive(1, 64'h66, 8'h66, 0, 0, 0);
    step();
    drive(0, 64'h0, 8'h00, 0, 0, 0);
    check("ar_pre_occ", {62'd0, occupancy}, 64'd2);
    #1;
    reset = 1'b0;
    #1;
    check("ar_valid", {63'd0, out_valid}, 64'd0);
    check("ar_in_ready", {63'd0, in_ready}, 64'd1);
    check("ar_occ", {62'd0, occupancy}, 64'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 1) != 0), {$urandom, $urandom}, 8'($urandom),
            ($urandom_range(0, 1) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 20) == 0));
      step();
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
